// File: rtl/inst_loader.sv
// Boot-time instruction loader: parses a counted, checksummed byte image into 16-bit
// words, writes them to sequential instruction-memory addresses, then releases the core.
module inst_loader #(
    parameter int PC_WIDTH  = 16,
    parameter int ISA_WIDTH = 16,
    parameter int MAX_WORDS = 256
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start_i,
    input  logic                 rx_valid_i,
    input  logic [7:0]           rx_data_i,
    output logic                 rx_ready_o,
    output logic                 inst_wen_o,
    output logic [PC_WIDTH-1:0]  inst_addr_o,
    output logic [ISA_WIDTH-1:0] inst_data_o,
    output logic                 cpu_rst_n_o,
    output logic                 load_done_o,
    output logic                 load_err_o
);

    typedef enum logic [2:0] {
        S_HDR_HI,
        S_HDR_LO,
        S_WORD_HI,
        S_WORD_LO,
        S_CSUM,
        S_DONE,
        S_ERROR
    } state_e;

    state_e                state_q, state_d;
    logic [7:0]            cnt_hi_q, cnt_hi_d;
    logic [15:0]           n_q, n_d;
    logic [7:0]            word_hi_q, word_hi_d;
    logic [7:0]            sum_q, sum_d;
    logic [PC_WIDTH-1:0]   word_idx_q, word_idx_d;
    logic                  inst_wen_q, inst_wen_d;
    logic [PC_WIDTH-1:0]   inst_addr_q, inst_addr_d;
    logic [ISA_WIDTH-1:0]  inst_data_q, inst_data_d;
    logic                  cpu_rst_n_q, cpu_rst_n_d;
    logic                  load_done_q, load_done_d;
    logic                  load_err_q, load_err_d;

    logic                  xfer;
    logic [15:0]           n_hdr;
    logic                  last_word;

    assign xfer      = rx_valid_i & rx_ready_o;
    assign n_hdr     = {cnt_hi_q, rx_data_i};
    assign last_word = (32'(word_idx_q) + 32'd1) == 32'(n_q);

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_HDR_HI;
            cnt_hi_q    <= '0;
            n_q         <= '0;
            word_hi_q   <= '0;
            sum_q       <= '0;
            word_idx_q  <= '0;
            inst_wen_q  <= 1'b0;
            inst_addr_q <= '0;
            inst_data_q <= '0;
            cpu_rst_n_q <= 1'b0;
            load_done_q <= 1'b0;
            load_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_hi_q    <= cnt_hi_d;
            n_q         <= n_d;
            word_hi_q   <= word_hi_d;
            sum_q       <= sum_d;
            word_idx_q  <= word_idx_d;
            inst_wen_q  <= inst_wen_d;
            inst_addr_q <= inst_addr_d;
            inst_data_q <= inst_data_d;
            cpu_rst_n_q <= cpu_rst_n_d;
            load_done_q <= load_done_d;
            load_err_q  <= load_err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_HDR_HI:  if (xfer) state_d = S_HDR_LO;
            S_HDR_LO: begin
                if (xfer) begin
                    if (32'(n_hdr) > 32'(MAX_WORDS)) state_d = S_ERROR;
                    else if (n_hdr == 16'd0)         state_d = S_CSUM;
                    else                             state_d = S_WORD_HI;
                end
            end
            S_WORD_HI: if (xfer) state_d = S_WORD_LO;
            S_WORD_LO: if (xfer) state_d = last_word ? S_CSUM : S_WORD_HI;
            S_CSUM:    if (xfer) state_d = (rx_data_i == sum_q) ? S_DONE : S_ERROR;
            S_DONE,
            S_ERROR:   if (start_i) state_d = S_HDR_HI;
            default:   state_d = S_HDR_HI;
        endcase
    end

    // Outputs and datapath next-state; status flags track the state being entered
    always_comb begin
        rx_ready_o  = 1'b0;
        cnt_hi_d    = cnt_hi_q;
        n_d         = n_q;
        word_hi_d   = word_hi_q;
        sum_d       = sum_q;
        word_idx_d  = word_idx_q;
        inst_wen_d  = 1'b0;
        inst_addr_d = inst_addr_q;
        inst_data_d = inst_data_q;
        cpu_rst_n_d = (state_d == S_DONE);
        load_done_d = (state_d == S_DONE);
        load_err_d  = (state_d == S_ERROR);
        case (state_q)
            S_HDR_HI: begin
                rx_ready_o = 1'b1;
                if (xfer) begin
                    cnt_hi_d = rx_data_i;
                    sum_d    = sum_q + rx_data_i;
                end
            end
            S_HDR_LO: begin
                rx_ready_o = 1'b1;
                if (xfer) begin
                    n_d   = n_hdr;
                    sum_d = sum_q + rx_data_i;
                end
            end
            S_WORD_HI: begin
                rx_ready_o = 1'b1;
                if (xfer) begin
                    word_hi_d = rx_data_i;
                    sum_d     = sum_q + rx_data_i;
                end
            end
            S_WORD_LO: begin
                rx_ready_o = 1'b1;
                if (xfer) begin
                    inst_wen_d  = 1'b1;
                    inst_addr_d = word_idx_q;
                    inst_data_d = ISA_WIDTH'({word_hi_q, rx_data_i});
                    word_idx_d  = word_idx_q + PC_WIDTH'(1);
                    sum_d       = sum_q + rx_data_i;
                end
            end
            S_CSUM: begin
                rx_ready_o = 1'b1;
            end
            S_DONE,
            S_ERROR: begin
                if (start_i) begin
                    sum_d       = '0;
                    word_idx_d  = '0;
                    inst_addr_d = '0;
                end
            end
            default: ;
        endcase
    end

    assign inst_wen_o  = inst_wen_q;
    assign inst_addr_o = inst_addr_q;
    assign inst_data_o = inst_data_q;
    assign cpu_rst_n_o = cpu_rst_n_q;
    assign load_done_o = load_done_q;
    assign load_err_o  = load_err_q;

endmodule

// File: tb/tb_inst_loader.sv
// Bench for inst_loader: table of known images, hand-written restart/reset sequences,
// and random images checked against a parse-the-image reference model.
module tb_inst_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_ready;
    logic        inst_wen;
    logic [15:0] inst_addr;
    logic [15:0] inst_data;
    logic        cpu_rst_n;
    logic        load_done;
    logic        load_err;

    int n_tests = 0;
    int n_fail  = 0;

    typedef logic [7:0] bq_t[$];
    typedef struct { int consumed; bit done; bit err; } res_t;
    typedef struct { logic [7:0] b[8]; int len; bit exp_done; int exp_nwr; } vec_t;

    logic [31:0] wr_q[$];
    logic [31:0] exp_wr[$];
    res_t        cur_r;
    bq_t         img_q;

    inst_loader #(.PC_WIDTH(16), .ISA_WIDTH(16), .MAX_WORDS(256)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_i    (start),
        .rx_valid_i (rx_valid),
        .rx_data_i  (rx_data),
        .rx_ready_o (rx_ready),
        .inst_wen_o (inst_wen),
        .inst_addr_o(inst_addr),
        .inst_data_o(inst_data),
        .cpu_rst_n_o(cpu_rst_n),
        .load_done_o(load_done),
        .load_err_o (load_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (inst_wen === 1'b1) wr_q.push_back({inst_addr, inst_data});

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference: read the image as a document -- header count, word list, trailing sum
    task automatic model(input bq_t img);
        int n;
        logic [7:0] sum;
        exp_wr.delete();
        n   = {img[0], img[1]};
        sum = img[0] + img[1];
        if (n > 256) begin
            cur_r.consumed = 2; cur_r.done = 0; cur_r.err = 1;
        end else begin
            for (int k = 0; k < n; k++) begin
                exp_wr.push_back({16'(k), img[2+2*k], img[3+2*k]});
                sum = sum + img[2+2*k] + img[3+2*k];
            end
            cur_r.consumed = 3 + 2*n;
            cur_r.done     = (img[2+2*n] == sum);
            cur_r.err      = !cur_r.done;
        end
    endtask

    // Drive bytes [from,to) one per handshake, with random idle gaps; must be called at a negedge
    task automatic send(input bq_t img, input int from, input int to, input int max_gap);
        int n;
        int g;
        bit is_wlo;
        n = {img[0], img[1]};
        for (int i = from; i < to; i++) begin
            g = (max_gap > 0) ? $urandom_range(0, max_gap) : 0;
            if (g > 0) begin
                rx_valid = 1'b0;
                repeat (g) @(negedge clk);
            end
            rx_valid = 1'b1;
            rx_data  = img[i];
            chk($sformatf("rx_ready byte %0d", i), rx_ready, 1);
            @(negedge clk);
            is_wlo = (n <= 256) && (i >= 2) && (i < 2 + 2*n) && (((i - 2) % 2) == 1);
            chk($sformatf("wen after byte %0d", i), inst_wen, is_wlo);
        end
        rx_valid = 1'b0;
    endtask

    task automatic post_check(input string tag);
        chk({tag, " load_done"}, load_done, cur_r.done);
        chk({tag, " load_err"}, load_err, cur_r.err);
        chk({tag, " cpu_rst_n"}, cpu_rst_n, cur_r.done);
        chk({tag, " rx_ready"}, rx_ready, 0);
        chk({tag, " nwrites"}, wr_q.size(), exp_wr.size());
        for (int k = 0; k < wr_q.size() && k < exp_wr.size(); k++)
            chk($sformatf("%s write %0d", tag, k), wr_q[k], exp_wr[k]);
    endtask

    task automatic run_image(input bq_t img, input int gap, input string tag);
        model(img);
        wr_q.delete();
        send(img, 0, cur_r.consumed, gap);
        post_check(tag);
    endtask

    task automatic do_start(input string tag);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({tag, " start cpu_rst_n"}, cpu_rst_n, 0);
        chk({tag, " start load_done"}, load_done, 0);
        chk({tag, " start load_err"}, load_err, 0);
        chk({tag, " start rx_ready"}, rx_ready, 1);
        chk({tag, " start inst_addr"}, inst_addr, 0);
    endtask

    vec_t tbl[7];

    initial begin
        // Checksum of 00 02 12 34 AB CD is C0 (mod-256 sum)
        tbl[0] = '{b: '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hC0, 8'h00}, len: 7, exp_done: 1, exp_nwr: 2};
        tbl[1] = '{b: '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hC1, 8'h00}, len: 7, exp_done: 0, exp_nwr: 2};
        tbl[2] = '{b: '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h70, 8'h00}, len: 7, exp_done: 0, exp_nwr: 2};
        tbl[3] = '{b: '{8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, len: 2, exp_done: 0, exp_nwr: 0};
        tbl[4] = '{b: '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, len: 3, exp_done: 1, exp_nwr: 0};
        tbl[5] = '{b: '{8'h00, 8'h01, 8'hBE, 8'hEF, 8'hAE, 8'h00, 8'h00, 8'h00}, len: 5, exp_done: 1, exp_nwr: 1};
        tbl[6] = '{b: '{8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, len: 2, exp_done: 0, exp_nwr: 0};

        repeat (3) @(negedge clk);
        chk("reset rx_ready", rx_ready, 1);
        chk("reset cpu_rst_n", cpu_rst_n, 0);
        chk("reset inst_wen", inst_wen, 0);
        chk("reset inst_addr", inst_addr, 0);
        chk("reset inst_data", inst_data, 0);
        chk("reset load_done", load_done, 0);
        chk("reset load_err", load_err, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // start while idle in the header state must be harmless
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("idle start rx_ready", rx_ready, 1);

        for (int t = 0; t < 7; t++) begin
            img_q.delete();
            for (int j = 0; j < tbl[t].len; j++) img_q.push_back(tbl[t].b[j]);
            run_image(img_q, 0, $sformatf("tbl%0d", t));
            chk($sformatf("tbl%0d const done", t), load_done, tbl[t].exp_done);
            chk($sformatf("tbl%0d const nwr", t), wr_q.size(), tbl[t].exp_nwr);
            do_start($sformatf("tbl%0d", t));
        end

        // start mid-image is ignored; the load completes normally
        img_q.delete();
        for (int j = 0; j < 7; j++) img_q.push_back(tbl[0].b[j]);
        model(img_q);
        wr_q.delete();
        send(img_q, 0, 3, 0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        send(img_q, 3, 7, 0);
        post_check("midstart");
        do_start("midstart");

        // reset after byte 3 aborts; a fresh image then loads from address 0
        send(img_q, 0, 3, 2);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midreset rx_ready", rx_ready, 1);
        chk("midreset inst_addr", inst_addr, 0);
        chk("midreset cpu_rst_n", cpu_rst_n, 0);
        rst_n = 1'b1;
        @(negedge clk);
        run_image(img_q, 5, "gapped");
        do_start("gapped");

        // largest accepted image
        img_q.delete();
        begin
            logic [7:0] s;
            img_q.push_back(8'h01); img_q.push_back(8'h00);
            s = 8'h01;
            for (int k = 0; k < 512; k++) begin
                logic [7:0] b;
                b = 8'($urandom);
                img_q.push_back(b);
                s = s + b;
            end
            img_q.push_back(s);
        end
        run_image(img_q, 0, "max256");
        do_start("max256");

        for (int r = 0; r < 25; r++) begin
            int n;
            int kind;
            logic [7:0] s;
            img_q.delete();
            kind = $urandom_range(0, 9);
            n = (kind == 0) ? $urandom_range(257, 1000) : $urandom_range(0, 6);
            img_q.push_back(8'(n >> 8));
            img_q.push_back(8'(n));
            s = 8'(n >> 8) + 8'(n);
            if (n <= 256) begin
                for (int k = 0; k < 2*n; k++) begin
                    logic [7:0] b;
                    b = 8'($urandom);
                    img_q.push_back(b);
                    s = s + b;
                end
                if (kind < 3) s = s + 8'($urandom_range(1, 255));
                img_q.push_back(s);
            end
            run_image(img_q, $urandom_range(0, 3), $sformatf("rand%0d", r));
            do_start($sformatf("rand%0d", r));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
